// File: rtl/cpu_irq_ctrl_pkg.sv
// Shared definitions for the CPU interrupt controller: FSM encodings,
// default handler-vector layout and the vector address helper.
package cpu_irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Default handler layout; cpu_pc uses the same values for vector checks.
  localparam logic [31:0] DEF_VEC_BASE   = 32'h0000_0100;
  localparam logic [31:0] DEF_VEC_STRIDE = 32'h0000_0010;

  // Handler address for a source; wraps modulo 2^32.
  function automatic logic [31:0] vec_addr(input logic [31:0] base,
                                           input logic [31:0] stride,
                                           input logic [31:0] id);
    return base + id * stride;
  endfunction

endpackage

// File: rtl/cpu_irq_rr_arb.sv
// Combinational round-robin picker: the search starts one past the
// previously serviced source and wraps; the first requesting index wins.
module cpu_irq_rr_arb #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

  // Walk the sources in rotated order, keeping the first hit.
  always_comb begin
    logic [ID_W-1:0] cand;
    gnt_valid = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = ID_W'((int'(last_id) + k) % NUM_SRC);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_id    = cand;
      end
    end
  end

endmodule

// File: rtl/cpu_irq_ctrl.sv
// Interrupt controller in front of cpu_pc: captures rising edges into a
// pending register, masks them, picks a winner round-robin and holds the
// request until granted, then blocks until end-of-interrupt.
module cpu_irq_ctrl
  import cpu_irq_ctrl_pkg::*;
#(
  parameter int          NUM_SRC    = 4,
  parameter logic [31:0] VEC_BASE   = DEF_VEC_BASE,
  parameter logic [31:0] VEC_STRIDE = DEF_VEC_STRIDE,
  localparam int         ID_W       = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               eoi,
  input  logic               interrupt_grant,
  output logic               interrupt,
  output logic [ID_W-1:0]    irq_id,
  output logic [31:0]        irq_vector,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy
);

  irq_state_e         state, state_nxt;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    last_id;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_valid;
  logic               interrupt_nxt;
  logic               busy_nxt;

  assign eligible = pending & mask;
  assign rise     = irq_src & ~src_q;

  cpu_irq_rr_arb #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_arb (
    .req       (eligible),
    .last_id   (last_id),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // State register; interrupt/busy are registered copies of the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      interrupt <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      interrupt <= interrupt_nxt;
      busy      <= busy_nxt;
    end
  end

  // Next-state: grant only matters in REQ, eoi only in SERVICE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (gnt_valid)       state_nxt = ST_REQ;
      ST_REQ:     if (interrupt_grant) state_nxt = ST_SERVICE;
      ST_SERVICE: if (eoi)             state_nxt = ST_IDLE;
      default:                         state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so the outputs come straight from flops.
  always_comb begin
    interrupt_nxt = (state_nxt == ST_REQ);
    busy_nxt      = (state_nxt == ST_SERVICE);
  end

  // One-hot clear of the granted source's pending bit.
  always_comb begin
    clr = '0;
    if (state == ST_REQ && interrupt_grant) clr[irq_id] = 1'b1;
  end

  // Edge capture, pending accumulation (set beats clear) and mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q   <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      src_q   <= irq_src;
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wdata;
    end
  end

  // Winner latch on leaving IDLE; round-robin pointer advances on eoi.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_id     <= '0;
      irq_vector <= VEC_BASE;
      last_id    <= ID_W'(NUM_SRC - 1);
    end else begin
      if (state == ST_IDLE && gnt_valid) begin
        irq_id     <= gnt_id;
        irq_vector <= vec_addr(VEC_BASE, VEC_STRIDE, 32'(gnt_id));
      end
      if (state == ST_SERVICE && eoi) last_id <= irq_id;
    end
  end

endmodule

// File: tb/tb_cpu_irq_ctrl.sv
// Randomized bench for cpu_irq_ctrl with a behavioural reference model and
// a request scoreboard drained by an independent monitor.
module tb_cpu_irq_ctrl;

  localparam int          N  = 4;
  localparam logic [31:0] VB = 32'h0000_0100;
  localparam logic [31:0] VS = 32'h0000_0010;

  logic         clk;
  logic         reset;
  logic [N-1:0] irq_src;
  logic         mask_we;
  logic [N-1:0] mask_wdata;
  logic         eoi;
  logic         interrupt_grant;
  logic         interrupt;
  logic [1:0]   irq_id;
  logic [31:0]  irq_vector;
  logic [N-1:0] pending;
  logic         busy;

  cpu_irq_ctrl #(
    .NUM_SRC    (N),
    .VEC_BASE   (VB),
    .VEC_STRIDE (VS)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .irq_src         (irq_src),
    .mask_we         (mask_we),
    .mask_wdata      (mask_wdata),
    .eoi             (eoi),
    .interrupt_grant (interrupt_grant),
    .interrupt       (interrupt),
    .irq_id          (irq_id),
    .irq_vector      (irq_vector),
    .pending         (pending),
    .busy            (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          id;
    logic [31:0] vec;
  } req_t;

  req_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: phase 0 = waiting, 1 = requesting, 2 = in service.
  logic [N-1:0] m_src_q, m_pend, m_mask;
  int           m_last, m_phase, m_id;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_src_q = '0;
    m_pend  = '0;
    m_mask  = '0;
    m_last  = N - 1;
    m_phase = 0;
    m_id    = 0;
  endfunction

  // One clock of the reference model, using the inputs the DUT samples now.
  function automatic void model_step();
    logic [N-1:0] elig;
    logic [N-1:0] clear;
    int           best, bestd, d;
    elig  = m_pend & m_mask;
    clear = '0;
    if (m_phase == 0) begin
      // Winner: eligible source at the smallest circular distance past m_last.
      best  = -1;
      bestd = N;
      for (int i = 0; i < N; i++) begin
        if (elig[i]) begin
          d = (i - m_last - 1 + 2 * N) % N;
          if (d < bestd) begin
            bestd = d;
            best  = i;
          end
        end
      end
      if (best >= 0) begin
        req_t r;
        m_phase = 1;
        m_id    = best;
        r.id    = best;
        r.vec   = VB + 32'(best) * VS;
        exp_q.push_back(r);
      end
    end else if (m_phase == 1) begin
      if (interrupt_grant) begin
        clear[m_id] = 1'b1;
        m_phase     = 2;
      end
    end else begin
      if (eoi) begin
        m_last  = m_id;
        m_phase = 0;
      end
    end
    m_pend  = (m_pend & ~clear) | (irq_src & ~m_src_q);
    m_src_q = irq_src;
    if (mask_we) m_mask = mask_wdata;
  endfunction

  // Monitor: per-cycle output checks plus scoreboard pop on each new request.
  logic int_prev;
  always @(negedge clk) begin
    if (reset) begin
      int_prev = 1'b0;
    end else begin
      check("interrupt", 32'(interrupt), 32'(m_phase == 1));
      check("busy", 32'(busy), 32'(m_phase == 2));
      check("pending", 32'(pending), 32'(m_pend));
      if (m_phase != 0) begin
        check("held_id", 32'(irq_id), 32'(m_id));
        check("held_vector", irq_vector, VB + 32'(m_id) * VS);
      end
      if (interrupt && !int_prev) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_request: got id %0d, expected no request (t=%0t)", irq_id, $time);
        end else begin
          req_t e;
          e = exp_q.pop_front();
          check("req_id", 32'(irq_id), 32'(e.id));
          check("req_vector", irq_vector, e.vec);
        end
      end
      int_prev = interrupt;
    end
  end

  task automatic drive_random();
    for (int b = 0; b < N; b++)
      if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
    mask_we    = ($urandom_range(0, 15) == 0);
    mask_wdata = ($urandom_range(0, 1) == 1) ? '1 : N'($urandom);
    if (m_phase == 1) interrupt_grant = ($urandom_range(0, 2) == 0);
    else              interrupt_grant = ($urandom_range(0, 19) == 0);
    if (m_phase == 2) eoi = ($urandom_range(0, 3) == 0);
    else              eoi = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    reset           = 1'b1;
    irq_src         = '0;
    mask_we         = 1'b0;
    mask_wdata      = '0;
    eoi             = 1'b0;
    interrupt_grant = 1'b0;
    model_reset();

    #100;
    check("rst_interrupt", 32'(interrupt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irq_id", 32'(irq_id), 32'd0);
    check("rst_irq_vector", irq_vector, VB);
    check("rst_pending", 32'(pending), 32'd0);

    @(posedge clk);
    #2;
    reset      = 1'b0;
    mask_we    = 1'b1;
    mask_wdata = '1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      model_step();
      #2;
      if (m_phase == 1 && $urandom_range(0, 15) == 0) begin
        // Asynchronous reset between edges must clear outputs immediately.
        reset = 1'b1;
        #1;
        check("async_rst_interrupt", 32'(interrupt), 32'd0);
        check("async_rst_pending", 32'(pending), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_vector", irq_vector, VB);
        model_reset();
        exp_q.delete();
        @(posedge clk);
        #2;
        reset = 1'b0;
      end
      drive_random();
    end

    mask_we         = 1'b0;
    eoi             = 1'b0;
    interrupt_grant = 1'b0;
    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
